// File: rtl/delay_tap_ctrl.sv
// rtl/delay_tap_ctrl.sv - run-time tap controller for a VAR_LOAD IDELAYE2/ODELAYE2
//
// Purpose:
//   Waits for the delay controller's RDY (after a 2-flop synchronizer) and then
//   loads the current tap into the primitive. It then accepts target tap requests
//   over a valid/ready handshake. Each move is one tap at a time, so live data
//   only ever sees single-tap steps. After every load or move it checks the
//   primitive's CNTVALUEOUT against the tap it expects.
//
// Ports:
//   i_clk           system clock (also the primitive's C pin)
//   i_rst           synchronous active-high reset
//   i_delay_rdy     RDY from idelayctrl, asynchronous to i_clk
//   i_tap_in        requested target tap, sampled only on acceptance
//   i_tap_valid     request valid
//   o_tap_ready     controller can accept a request (IDLE)
//   i_cnt_out       CNTVALUEOUT from the primitive
//   o_dly_ld        LD to the primitive
//   o_dly_ce        CE to the primitive
//   o_dly_inc       INC to the primitive (holds while CE is low)
//   o_dly_cntvalue  CNTVALUEIN to the primitive (always equals o_tap)
//   o_tap           tap the controller believes is applied
//   o_busy          controller is not in IDLE
//   o_error         sticky verify mismatch / RDY loss, cleared by an accepted request

module delay_tap_ctrl #(
  parameter int INIT_TAP    = 0,
  parameter int STEP_GAP    = 4,
  parameter int CHECK_DELAY = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_delay_rdy,
  input  logic [4:0] i_tap_in,
  input  logic       i_tap_valid,
  output logic       o_tap_ready,
  input  logic [4:0] i_cnt_out,
  output logic       o_dly_ld,
  output logic       o_dly_ce,
  output logic       o_dly_inc,
  output logic [4:0] o_dly_cntvalue,
  output logic [4:0] o_tap,
  output logic       o_busy,
  output logic       o_error
);

  typedef enum logic [2:0] {
    S_WAIT_RDY,
    S_LOAD,
    S_IDLE,
    S_STEP,
    S_GAP,
    S_CHECK
  } state_t;

  localparam logic [4:0] TAP_RST   = 5'(INIT_TAP);
  localparam logic [7:0] GAP_LAST  = 8'(STEP_GAP - 1);
  localparam logic [7:0] CHK_LAST  = 8'(CHECK_DELAY);

  state_t     r_state;
  logic       r_rdy_meta;
  logic       r_rdy_s;
  logic [7:0] r_cnt;
  logic [4:0] r_tap;
  logic [4:0] r_target;
  logic       r_ld;
  logic       r_ce;
  logic       r_inc;
  logic       r_ready;
  logic       r_busy;
  logic       r_error;

  state_t     w_state_nxt;
  logic [7:0] w_cnt_nxt;
  logic [4:0] w_tap_nxt;
  logic [4:0] w_target_nxt;
  logic       w_inc_nxt;
  logic       w_error_nxt;

  // RDY crosses from the idelayctrl domain
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdy_meta <= 1'b0;
      r_rdy_s    <= 1'b0;
    end else begin
      r_rdy_meta <= i_delay_rdy;
      r_rdy_s    <= r_rdy_meta;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_WAIT_RDY;
      r_cnt    <= '0;
      r_tap    <= TAP_RST;
      r_target <= TAP_RST;
      r_ld     <= 1'b0;
      r_ce     <= 1'b0;
      r_inc    <= 1'b0;
      r_ready  <= 1'b0;
      r_busy   <= 1'b1;
      r_error  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_tap    <= w_tap_nxt;
      r_target <= w_target_nxt;
      r_ld     <= (w_state_nxt == S_LOAD);
      r_ce     <= (w_state_nxt == S_STEP);
      r_inc    <= w_inc_nxt;
      r_ready  <= (w_state_nxt == S_IDLE);
      r_busy   <= (w_state_nxt != S_IDLE);
      r_error  <= w_error_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_tap_nxt    = r_tap;
    w_target_nxt = r_target;
    w_inc_nxt    = r_inc;
    w_error_nxt  = r_error;

    // The CE pulse of a STEP cycle is seen by the primitive on the edge that
    // ends it, so the tap follows even if that same edge aborts on RDY loss.
    if (r_state == S_STEP) begin
      w_tap_nxt = r_inc ? (r_tap + 5'd1) : (r_tap - 5'd1);
    end

    case (r_state)
      S_WAIT_RDY: begin
        if (r_rdy_s) begin
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        w_state_nxt = S_CHECK;
        w_cnt_nxt   = '0;
      end
      S_IDLE: begin
        if (i_tap_valid) begin
          w_target_nxt = i_tap_in;
          w_error_nxt  = 1'b0;
          w_cnt_nxt    = '0;
          w_state_nxt  = (i_tap_in == r_tap) ? S_CHECK : S_STEP;
        end
      end
      S_STEP: begin
        w_state_nxt = S_GAP;
        w_cnt_nxt   = '0;
      end
      S_GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = (r_tap == r_target) ? S_CHECK : S_STEP;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_CHECK: begin
        if (r_cnt == CHK_LAST) begin
          if (i_cnt_out != r_tap) begin
            w_error_nxt = 1'b1;
          end
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = S_WAIT_RDY;
      end
    endcase

    // Losing lock beats everything, including a request on the same cycle
    if ((r_state != S_WAIT_RDY) && !r_rdy_s) begin
      w_state_nxt  = S_WAIT_RDY;
      w_target_nxt = r_target;
      w_error_nxt  = 1'b1;
      w_cnt_nxt    = '0;
    end

    // INC is only refreshed with a new CE pulse; direction comes from the
    // target and tap that will be current during that STEP cycle.
    if (w_state_nxt == S_STEP) begin
      w_inc_nxt = (w_target_nxt > w_tap_nxt);
    end
  end

  assign o_tap_ready    = r_ready;
  assign o_dly_ld       = r_ld;
  assign o_dly_ce       = r_ce;
  assign o_dly_inc      = r_inc;
  assign o_dly_cntvalue = r_tap;
  assign o_tap          = r_tap;
  assign o_busy         = r_busy;
  assign o_error        = r_error;

endmodule

// File: tb/tb_delay_tap_ctrl.sv
// tb/tb_delay_tap_ctrl.sv - directed self-checking bench for delay_tap_ctrl

module tb_delay_tap_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       delay_rdy = 1'b0;
  logic [4:0] tap_in = 5'd0;
  logic       tap_valid = 1'b0;
  logic       tap_ready;
  logic [4:0] cnt_out;
  logic       dly_ld;
  logic       dly_ce;
  logic       dly_inc;
  logic [4:0] dly_cntvalue;
  logic [4:0] tap;
  logic       busy;
  logic       error;

  int errors = 0;
  int checks = 0;

  // Environment model of the delay primitive's counter
  logic [4:0] m_cnt = 5'd0;
  logic       stuck = 1'b0;
  assign cnt_out = stuck ? 5'd0 : m_cnt;

  // Cumulative monitor counters, sampled on the falling edge
  int cyc = 0;
  int ce_total = 0;
  int ld_total = 0;
  int both_hi = 0;
  int saw31 = 0;
  int ce_cyc[$];

  always #5 clk = ~clk;

  delay_tap_ctrl #(
    .INIT_TAP   (5),
    .STEP_GAP   (4),
    .CHECK_DELAY(2)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_delay_rdy   (delay_rdy),
    .i_tap_in      (tap_in),
    .i_tap_valid   (tap_valid),
    .o_tap_ready   (tap_ready),
    .i_cnt_out     (cnt_out),
    .o_dly_ld      (dly_ld),
    .o_dly_ce      (dly_ce),
    .o_dly_inc     (dly_inc),
    .o_dly_cntvalue(dly_cntvalue),
    .o_tap         (tap),
    .o_busy        (busy),
    .o_error       (error)
  );

  always @(posedge clk) begin
    if (dly_ld)      m_cnt <= dly_cntvalue;
    else if (dly_ce) m_cnt <= dly_inc ? m_cnt + 5'd1 : m_cnt - 5'd1;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (dly_ce) begin
        ce_total = ce_total + 1;
        ce_cyc.push_back(cyc);
      end
      if (dly_ld) ld_total = ld_total + 1;
      if (dly_ld && dly_ce) both_hi = both_hi + 1;
      if (tap == 5'd31) saw31 = saw31 + 1;
    end
    cyc = cyc + 1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until tap_ready rises; bounded
  task automatic wait_ready(output int n);
    n = 0;
    while (n < 200) begin
      tick();
      n++;
      if (tap_ready) break;
    end
  endtask

  // Accept one request; returns with the accept edge just passed
  task automatic request(input logic [4:0] t);
    tap_in    = t;
    tap_valid = 1'b1;
    tick();
    tap_valid = 1'b0;
    tap_in    = 5'd17;
  endtask

  function automatic int spacing_bad(input int from);
    int bad = 0;
    for (int i = from + 1; i < ce_cyc.size(); i++) begin
      if (ce_cyc[i] - ce_cyc[i-1] != 5) bad++;
    end
    return bad;
  endfunction

  initial begin
    int n;
    int ce0;
    int ld0;
    int q0;

    // Reset state
    delay_rdy = 1'b1;
    tick();
    tick();
    check("rst_tap", tap, 5);
    check("rst_cntvalue", dly_cntvalue, 5);
    check("rst_ld", dly_ld, 0);
    check("rst_ce", dly_ce, 0);
    check("rst_inc", dly_inc, 0);
    check("rst_ready", tap_ready, 0);
    check("rst_error", error, 0);
    check("rst_busy", busy, 1);

    // Power-up: LOAD on the 3rd edge after release, IDLE on the 7th
    ld0 = ld_total;
    rst = 1'b0;
    tick();
    check("pu_ld_c1", dly_ld, 0);
    tick();
    check("pu_ld_c2", dly_ld, 0);
    tick();
    check("pu_ld_c3", dly_ld, 1);
    check("pu_cntvalue", dly_cntvalue, 5);
    tick();
    check("pu_ld_c4", dly_ld, 0);
    tick();
    tick();
    check("pu_ready_c6", tap_ready, 0);
    tick();
    check("pu_ready_c7", tap_ready, 1);
    check("pu_busy_c7", busy, 0);
    check("pu_error", error, 0);
    check("pu_ld_count", ld_total - ld0, 1);

    // Increment 5 -> 8: 3*(1+4)+2+1 = 18 busy cycles
    ce0 = ce_total;
    q0  = ce_cyc.size();
    request(5'd8);
    check("inc_busy_at_accept", busy, 1);
    check("inc_ready_at_accept", tap_ready, 0);
    wait_ready(n);
    check("inc_latency", n, 18);
    check("inc_ce_count", ce_total - ce0, 3);
    check("inc_spacing", spacing_bad(q0), 0);
    check("inc_dir", dly_inc, 1);
    check("inc_tap", tap, 8);
    check("inc_error", error, 0);

    // Decrement 8 -> 0: 8*5+3 = 43 cycles, never passing through 31
    ce0 = ce_total;
    q0  = ce_cyc.size();
    request(5'd0);
    wait_ready(n);
    check("dec_latency", n, 43);
    check("dec_ce_count", ce_total - ce0, 8);
    check("dec_spacing", spacing_bad(q0), 0);
    check("dec_dir", dly_inc, 0);
    check("dec_tap", tap, 0);
    check("dec_no_wrap", saw31, 0);

    // Null request: CHECK only
    ce0 = ce_total;
    request(5'd0);
    wait_ready(n);
    check("null_latency", n, 3);
    check("null_ce_count", ce_total - ce0, 0);
    check("null_error", error, 0);

    // Verify fault: counter readback stuck at 0
    stuck = 1'b1;
    request(5'd4);
    wait_ready(n);
    check("vf_latency", n, 23);
    check("vf_tap", tap, 4);
    check("vf_error", error, 1);
    stuck = 1'b0;
    request(5'd4);
    check("vf_clear_on_accept", error, 0);
    wait_ready(n);
    check("vf_after_error", error, 0);

    // Move to 2 as the start of the RDY-loss move
    request(5'd2);
    wait_ready(n);
    check("rl_pre_tap", tap, 2);

    // 2 -> 12, drop RDY once tap reaches 6 (inside a gap)
    request(5'd12);
    n = 0;
    while (tap != 5'd6 && n < 100) begin
      tick();
      n++;
    end
    check("rl_reached_6", tap, 6);
    delay_rdy = 1'b0;
    tick();
    tick();
    tick();
    check("rl_error", error, 1);
    check("rl_busy", busy, 1);
    check("rl_ready", tap_ready, 0);
    check("rl_ce", dly_ce, 0);
    check("rl_tap", tap, 6);
    tick();
    tick();
    check("rl_hold_tap", tap, 6);

    // RDY returns: LOAD restores tap 6
    ld0 = ld_total;
    delay_rdy = 1'b1;
    tick();
    check("rr_ld_c1", dly_ld, 0);
    tick();
    check("rr_ld_c2", dly_ld, 0);
    tick();
    check("rr_ld_c3", dly_ld, 1);
    check("rr_cntvalue", dly_cntvalue, 6);
    wait_ready(n);
    check("rr_latency", n, 4);
    check("rr_ld_count", ld_total - ld0, 1);
    check("rr_error_sticky", error, 1);
    request(5'd6);
    check("rr_error_cleared", error, 0);
    wait_ready(n);
    check("rr_final_error", error, 0);
    check("rr_final_tap", tap, 6);

    check("ld_ce_exclusive", both_hi, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
